// File: rtl/miner_nonce_ctrl.sv
// ---------------------------------------------------------------------------
// miner_nonce_ctrl
//
// Control unit for a SHA256 miner with NUM_CORES iterative hashers, each
// taking LOOP = 1<<LOOP_LOG2 rounds per nonce.  It does the following:
//   - gives each core its own nonce stream (core k gets base + k, and base
//     advances by NUM_CORES at every issue)
//   - drives the shared round counter and the feedback select
//   - watches every core's hash[255:224] for a golden ticket
//   - queues golden nonces in a first-word-fall-through FIFO
//   - sequences run, halt and nonce-space exhaustion
//
// Optional build macro:
//   MINER_DIFF_MASK_EN  adds a diff_mask input. A core then matches when
//                       ((hash ^ GOLDEN_WORD) & diff_mask) == 0. Without the
//                       macro a match needs exact 32-bit equality.
//
// Ports:
//   hash_clk      clock
//   reset         synchronous reset, active high
//   halt_in       halt request, active low
//   new_work      one-cycle strobe: latch the work, restart the nonces
//   midstate_in   work midstate (256 bits)
//   data_in       work data tail (96 bits)
//   state_out     latched midstate, shared by all cores
//   data_out      latched data tail, shared by all cores
//   nonce_out     per-core nonce; core k is at [32k+31:32k]
//   feedback      hasher internal feedback select
//   cnt_out       hasher round counter; its MSB is fb_second
//   hash_top_in   per-core hash[255:224]
//   diff_mask     match mask (only with MINER_DIFF_MASK_EN)
//   gn_rd         pop the golden FIFO
//   gn_data       FIFO head; valid when gn_empty is low
//   gn_empty      FIFO empty
//   gn_overflow   sticky: a golden nonce was lost
//   exhausted     the nonce space has wrapped
//   running       FSM is in RUN
//   leds          base[31:24]
//
// FSM states:
//   state   | meaning
//   IDLE    | halted or just out of reset; base held, results discarded
//   RUN     | counting rounds and issuing nonces
//   EXHAUST | base would wrap; issuing stops until new_work
// ---------------------------------------------------------------------------
module miner_nonce_ctrl #(
    parameter int          NUM_CORES       = 2,
    parameter int          LOOP_LOG2       = 1,
    parameter int          GOLDEN_OFFSET   = 66,
    parameter int          FIFO_DEPTH_LOG2 = 2,
    parameter logic [31:0] NONCE_START     = 32'hF8000000,
    parameter logic [31:0] GOLDEN_WORD     = 32'ha41f32e7
) (
    input  logic                    hash_clk,
    input  logic                    reset,
    input  logic                    halt_in,
    input  logic                    new_work,
    input  logic [255:0]            midstate_in,
    input  logic [95:0]             data_in,
    output logic [255:0]            state_out,
    output logic [95:0]             data_out,
    output logic [32*NUM_CORES-1:0] nonce_out,
    output logic                    feedback,
    output logic [LOOP_LOG2:0]      cnt_out,
    input  logic [32*NUM_CORES-1:0] hash_top_in,
`ifdef MINER_DIFF_MASK_EN
    input  logic [31:0]             diff_mask,
`endif
    input  logic                    gn_rd,
    output logic [31:0]             gn_data,
    output logic                    gn_empty,
    output logic                    gn_overflow,
    output logic                    exhausted,
    output logic                    running,
    output logic [7:0]              leds
);

    localparam int CW    = LOOP_LOG2 + 1;
    localparam int LOOP  = 1 << LOOP_LOG2;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int AW    = (FIFO_DEPTH_LOG2 > 0) ? FIFO_DEPTH_LOG2 : 1;
    localparam int NW    = FIFO_DEPTH_LOG2 + 1;
    localparam int IW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    // Low LOOP_LOG2 bits of the counter. The mask is zero when LOOP_LOG2 = 0,
    // so an issue then happens every cycle and feedback stays low.
    localparam logic [CW-1:0] LOW_MASK = CW'(LOOP - 1);
    localparam logic [31:0]   SUP_INIT = 32'(GOLDEN_OFFSET);
    // A checked result belongs to the nonce issued GOLDEN_OFFSET issues earlier.
    localparam logic [31:0]   LAG      = 32'(NUM_CORES * GOLDEN_OFFSET);

    typedef enum logic [1:0] {IDLE, RUN, EXHAUST} state_t;

    state_t         state;
    logic [31:0]    base;
    logic [CW-1:0]  cnt;
    logic           feedback_d1;
    logic [31:0]    suppress;

    logic [CW-1:0]  cnt_next;
    logic           fb_next;
    logic           counting;
    logic           issue;
    logic [32:0]    base_sum;
    logic           wrap;
    logic           check_en;

    logic [NUM_CORES-1:0] match;
    logic [NUM_CORES-1:0] pend_vld;
    logic [31:0]          pend_nonce [NUM_CORES];
    logic [IW-1:0]        push_idx;
    logic                 push_vld;
    logic [31:0]          push_data;
    logic                 push_ok;
    logic                 pop;

    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [NW-1:0]  fifo_cnt;
    logic           fifo_full;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cnt_next = cnt + CW'(1);
    assign fb_next  = ((cnt_next & LOW_MASK) != '0);
    // The hashers keep cycling in EXHAUST so that in-flight nonces still
    // finish; only a halt freezes the counter.
    assign counting = ((state == RUN) && halt_in) || (state == EXHAUST);
    assign issue    = (state == RUN) && halt_in && ((cnt_next & LOW_MASK) == '0);
    assign base_sum = {1'b0, base} + 33'(NUM_CORES);
    assign wrap     = base_sum[32];
    assign check_en = (state != IDLE) && !feedback_d1 && (suppress == 32'd0);

    assign running  = (state == RUN);
    assign leds     = base[31:24];
    assign cnt_out  = cnt;

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state       <= IDLE;
            base        <= NONCE_START;
            cnt         <= '0;
            feedback    <= 1'b0;
            feedback_d1 <= 1'b0;
            exhausted   <= 1'b0;
            suppress    <= SUP_INIT;
            state_out   <= '0;
            data_out    <= '0;
            for (int k = 0; k < NUM_CORES; k++)
                nonce_out[32*k +: 32] <= NONCE_START + 32'(k);
        end else begin
            feedback_d1 <= feedback;

            unique case (state)
                IDLE: begin
                    if (halt_in)
                        state <= RUN;
                end
                RUN: begin
                    if (!halt_in)
                        state <= IDLE;
                    else if (issue && wrap && !new_work) begin
                        state     <= EXHAUST;
                        exhausted <= 1'b1;
                    end
                end
                EXHAUST: begin
                    if (new_work)
                        state <= RUN;
                end
                default: state <= IDLE;
            endcase

            if (new_work) begin
                state_out <= midstate_in;
                data_out  <= data_in;
                base      <= NONCE_START;
                cnt       <= '0;
                feedback  <= 1'b0;
                exhausted <= 1'b0;
                suppress  <= SUP_INIT;
                for (int k = 0; k < NUM_CORES; k++)
                    nonce_out[32*k +: 32] <= NONCE_START + 32'(k);
            end else begin
                if (counting) begin
                    cnt      <= cnt_next;
                    feedback <= fb_next;
                end
                // On a wrap the base stays at its last legal value.
                if (issue && !wrap) begin
                    base <= base_sum[31:0];
                    for (int k = 0; k < NUM_CORES; k++)
                        nonce_out[32*k +: 32] <= base_sum[31:0] + 32'(k);
                    if (suppress != 32'd0)
                        suppress <= suppress - 32'd1;
                end
            end
        end
    end

    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
`ifdef MINER_DIFF_MASK_EN
            match[k] = (((hash_top_in[32*k +: 32] ^ GOLDEN_WORD) & diff_mask) == 32'd0);
`else
            match[k] = (hash_top_in[32*k +: 32] == GOLDEN_WORD);
`endif
        end
    end

    // Lowest pending core wins the single FIFO write port.
    always_comb begin
        push_idx = '0;
        push_vld = 1'b0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (pend_vld[k]) begin
                push_idx = IW'(k);
                push_vld = 1'b1;
            end
        end
    end

    assign push_data = pend_nonce[push_idx];
    assign gn_empty  = (fifo_cnt == '0);
    assign fifo_full = (fifo_cnt == NW'(DEPTH));
    assign pop       = gn_rd && !gn_empty;
    // When the FIFO is full, a pop in the same cycle frees the slot the push needs.
    assign push_ok   = push_vld && (!fifo_full || pop);
    assign gn_data   = mem[rd_ptr];

    // A pending slot that is being pushed this cycle can take a new match.
    // Only a slot that stays occupied loses the new result.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            pend_vld    <= '0;
            gn_overflow <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (check_en && match[k]) begin
                    if (pend_vld[k] && !(push_vld && (push_idx == IW'(k)))) begin
                        gn_overflow <= 1'b1;
                    end else begin
                        pend_vld[k]   <= 1'b1;
                        pend_nonce[k] <= nonce_out[32*k +: 32] - LAG;
                    end
                end else if (push_vld && (push_idx == IW'(k))) begin
                    pend_vld[k] <= 1'b0;
                end
            end
            if (push_vld && !push_ok)
                gn_overflow <= 1'b1;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push_ok && !pop)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push_ok)
                fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_miner_nonce_ctrl.sv
module tb_miner_nonce_ctrl;

    localparam logic [31:0] GW = 32'ha41f32e7;

    logic hash_clk = 1'b0;
    always #5 hash_clk = ~hash_clk;

    // main instance (default parameters)
    logic         reset, halt_in, new_work, gn_rd;
    logic [255:0] midstate_in, state_out;
    logic [95:0]  data_in, data_out;
    logic [63:0]  nonce_out, hash_top_in;
    logic         feedback, gn_empty, gn_overflow, exhausted, running;
    logic [1:0]   cnt_out;
    logic [31:0]  gn_data;
    logic [7:0]   leds;

    // wrap instance (NONCE_START near the top of the nonce space)
    logic         w_reset, w_halt, w_new_work, w_gn_rd;
    logic [255:0] w_midstate, w_state_out;
    logic [95:0]  w_data, w_data_out;
    logic [63:0]  w_nonce, w_hash;
    logic         w_feedback, w_empty, w_overflow, w_exhausted, w_running;
    logic [1:0]   w_cnt;
    logic [31:0]  w_gn_data;
    logic [7:0]   w_leds;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q[$];

    miner_nonce_ctrl u_dut (
        .hash_clk(hash_clk), .reset(reset), .halt_in(halt_in), .new_work(new_work),
        .midstate_in(midstate_in), .data_in(data_in), .state_out(state_out), .data_out(data_out),
        .nonce_out(nonce_out), .feedback(feedback), .cnt_out(cnt_out), .hash_top_in(hash_top_in),
`ifdef MINER_DIFF_MASK_EN
        .diff_mask(32'hFFFFFFFF),
`endif
        .gn_rd(gn_rd), .gn_data(gn_data), .gn_empty(gn_empty), .gn_overflow(gn_overflow),
        .exhausted(exhausted), .running(running), .leds(leds)
    );

    miner_nonce_ctrl #(.NONCE_START(32'hFFFFFFFC)) u_wrap (
        .hash_clk(hash_clk), .reset(w_reset), .halt_in(w_halt), .new_work(w_new_work),
        .midstate_in(w_midstate), .data_in(w_data), .state_out(w_state_out), .data_out(w_data_out),
        .nonce_out(w_nonce), .feedback(w_feedback), .cnt_out(w_cnt), .hash_top_in(w_hash),
`ifdef MINER_DIFF_MASK_EN
        .diff_mask(32'hFFFFFFFF),
`endif
        .gn_rd(w_gn_rd), .gn_data(w_gn_data), .gn_empty(w_empty), .gn_overflow(w_overflow),
        .exhausted(w_exhausted), .running(w_running), .leds(w_leds)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance on falling edges until core 0 shows n0 in a check cycle (feedback high).
    task automatic wait_for(input logic [31:0] n0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge hash_clk);
            if (nonce_out[31:0] === n0 && feedback === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; halt_in = 1'b1;
        repeat (3) @(negedge hash_clk);
        vec_cnt++; if (nonce_out !== {32'hF8000001, 32'hF8000000}) begin err_cnt++; $display("FAIL rst_nonce got %h want f8000001f8000000", nonce_out); end
        vec_cnt++; if (feedback !== 1'b0 || cnt_out !== 2'd0) begin err_cnt++; $display("FAIL rst_cnt got fb=%b cnt=%0d want 0/0", feedback, cnt_out); end
        vec_cnt++; if (gn_empty !== 1'b1 || gn_overflow !== 1'b0) begin err_cnt++; $display("FAIL rst_fifo got empty=%b ovf=%b want 1/0", gn_empty, gn_overflow); end
        vec_cnt++; if (exhausted !== 1'b0 || running !== 1'b0) begin err_cnt++; $display("FAIL rst_state got exh=%b run=%b want 0/0", exhausted, running); end
        vec_cnt++; if (state_out !== 256'd0 || data_out !== 96'd0) begin err_cnt++; $display("FAIL rst_work got nonzero state_out/data_out"); end
        vec_cnt++; if (leds !== 8'hF8) begin err_cnt++; $display("FAIL rst_leds got %h want f8", leds); end
        reset = 1'b0;
        @(negedge hash_clk);
        vec_cnt++; if (running !== 1'b1 || feedback !== 1'b0) begin err_cnt++; $display("FAIL start_run got run=%b fb=%b want 1/0", running, feedback); end
        @(negedge hash_clk);
        vec_cnt++; if (feedback !== 1'b1 || nonce_out !== {32'hF8000001, 32'hF8000000}) begin err_cnt++; $display("FAIL first_round got fb=%b nonce=%h want 1/f8000001f8000000", feedback, nonce_out); end
        @(negedge hash_clk);
        vec_cnt++; if (nonce_out !== {32'hF8000003, 32'hF8000002}) begin err_cnt++; $display("FAIL first_issue got %h want f8000003f8000002", nonce_out); end
        vec_cnt++; if (feedback !== 1'b0 || cnt_out !== 2'd2) begin err_cnt++; $display("FAIL first_issue_cnt got fb=%b cnt=%0d want 0/2", feedback, cnt_out); end
    endtask

    task automatic test_single_golden;
        bit ok;
        logic [31:0] e;
        wait_for(32'hF80000A4, ok);
        vec_cnt++; if (!ok || nonce_out[63:32] !== 32'hF80000A5) begin err_cnt++; $display("FAIL single_sync got ok=%b nonce1=%h want 1/f80000a5", ok, nonce_out[63:32]); end
        hash_top_in = {GW, 32'h0};
        exp_q.push_back(32'hF80000A5 - 32'd132);
        @(negedge hash_clk);
        hash_top_in = '0;
        vec_cnt++; if (gn_empty !== 1'b1) begin err_cnt++; $display("FAIL single_lat1 got empty=%b want 1", gn_empty); end
        @(negedge hash_clk);
        vec_cnt++; if (gn_empty !== 1'b0) begin err_cnt++; $display("FAIL single_lat2 got empty=%b want 0", gn_empty); end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            if (!gn_empty) begin
                e = exp_q.pop_front();
                vec_cnt++; if (gn_data !== e) begin err_cnt++; $display("FAIL single_data got %h want %h", gn_data, e); end
                gn_rd = 1'b1;
            end else gn_rd = 1'b0;
            @(negedge hash_clk);
        end
        gn_rd = 1'b0;
        vec_cnt++; if (exp_q.size() != 0 || gn_empty !== 1'b1) begin err_cnt++; $display("FAIL single_drain got left=%0d empty=%b want 0/1", exp_q.size(), gn_empty); end
    endtask

    task automatic test_both_cores;
        bit ok;
        logic [31:0] e;
        wait_for(32'hF80000C0, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL both_sync got timeout want nonce f80000c0"); end
        hash_top_in = {GW, GW};
        exp_q.push_back(32'hF80000C0 - 32'd132);
        exp_q.push_back(32'hF80000C1 - 32'd132);
        @(negedge hash_clk);
        hash_top_in = '0;
        repeat (3) @(negedge hash_clk);
        vec_cnt++; if (gn_overflow !== 1'b0) begin err_cnt++; $display("FAIL both_ovf got %b want 0", gn_overflow); end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            if (!gn_empty) begin
                e = exp_q.pop_front();
                vec_cnt++; if (gn_data !== e) begin err_cnt++; $display("FAIL both_data got %h want %h", gn_data, e); end
                gn_rd = 1'b1;
            end else gn_rd = 1'b0;
            @(negedge hash_clk);
        end
        gn_rd = 1'b0;
        vec_cnt++; if (exp_q.size() != 0 || gn_empty !== 1'b1) begin err_cnt++; $display("FAIL both_drain got left=%0d empty=%b want 0/1", exp_q.size(), gn_empty); end
    endtask

    task automatic test_overflow;
        bit ok;
        logic [31:0] e;
        logic [31:0] tgt [3];
        logic [63:0] pat [3];
        tgt[0] = 32'hF8000100; pat[0] = {GW, GW};
        tgt[1] = 32'hF8000104; pat[1] = {GW, GW};
        tgt[2] = 32'hF8000108; pat[2] = {32'h0, GW};
        for (int t = 0; t < 3; t++) begin
            wait_for(tgt[t], ok);
            vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL ovf_sync%0d got timeout want nonce %h", t, tgt[t]); end
            hash_top_in = pat[t];
            // the fifth match (core 0 at 108) finds the FIFO full and is lost
            if (t < 2) begin
                exp_q.push_back(tgt[t] - 32'd132);
                exp_q.push_back(tgt[t] + 32'd1 - 32'd132);
            end
            @(negedge hash_clk);
            hash_top_in = '0;
        end
        repeat (4) @(negedge hash_clk);
        vec_cnt++; if (gn_overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag got %b want 1", gn_overflow); end
        for (int i = 0; i < 20 && !gn_empty; i++) begin
            if (exp_q.size() == 0) begin
                err_cnt++; vec_cnt++;
                $display("FAIL ovf_extra got unexpected entry %h want empty", gn_data);
            end else begin
                e = exp_q.pop_front();
                vec_cnt++; if (gn_data !== e) begin err_cnt++; $display("FAIL ovf_data got %h want %h", gn_data, e); end
            end
            gn_rd = 1'b1;
            @(negedge hash_clk);
            gn_rd = 1'b0;
        end
        vec_cnt++; if (exp_q.size() != 0) begin err_cnt++; $display("FAIL ovf_count got %0d missing want 0", exp_q.size()); end
        gn_rd = 1'b1;
        @(negedge hash_clk);
        gn_rd = 1'b0;
        vec_cnt++; if (gn_empty !== 1'b1 || gn_overflow !== 1'b1) begin err_cnt++; $display("FAIL rd_empty got empty=%b ovf=%b want 1/1", gn_empty, gn_overflow); end
    endtask

    task automatic test_halt;
        bit ok;
        wait_for(32'hF8000200, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL halt_sync got timeout want nonce f8000200"); end
        halt_in = 1'b0;
        @(negedge hash_clk);
        vec_cnt++; if (running !== 1'b0 || nonce_out[31:0] !== 32'hF8000200) begin err_cnt++; $display("FAIL halt_enter got run=%b nonce=%h want 0/f8000200", running, nonce_out[31:0]); end
        for (int i = 0; i < 9; i++) begin
            hash_top_in = {GW, GW};
            @(negedge hash_clk);
            vec_cnt++; if (nonce_out[31:0] !== 32'hF8000200 || gn_empty !== 1'b1) begin err_cnt++; $display("FAIL halt_hold%0d got nonce=%h empty=%b want f8000200/1", i, nonce_out[31:0], gn_empty); end
        end
        hash_top_in = '0;
        halt_in = 1'b1;
        @(negedge hash_clk);
        vec_cnt++; if (running !== 1'b1 || nonce_out[31:0] !== 32'hF8000200) begin err_cnt++; $display("FAIL halt_release got run=%b nonce=%h want 1/f8000200", running, nonce_out[31:0]); end
        @(negedge hash_clk);
        vec_cnt++; if (nonce_out !== {32'hF8000203, 32'hF8000202}) begin err_cnt++; $display("FAIL halt_resume got %h want f8000203f8000202", nonce_out); end
        // a reset while halted must restore every reset value
        halt_in = 1'b0;
        repeat (3) @(negedge hash_clk);
        reset = 1'b1;
        repeat (2) @(negedge hash_clk);
        vec_cnt++; if (nonce_out !== {32'hF8000001, 32'hF8000000}) begin err_cnt++; $display("FAIL hrst_nonce got %h want f8000001f8000000", nonce_out); end
        vec_cnt++; if (gn_overflow !== 1'b0 || gn_empty !== 1'b1) begin err_cnt++; $display("FAIL hrst_fifo got ovf=%b empty=%b want 0/1", gn_overflow, gn_empty); end
        vec_cnt++; if (cnt_out !== 2'd0 || feedback !== 1'b0 || running !== 1'b0 || exhausted !== 1'b0) begin err_cnt++; $display("FAIL hrst_ctl got cnt=%0d fb=%b run=%b exh=%b want 0/0/0/0", cnt_out, feedback, running, exhausted); end
        reset = 1'b0;
        repeat (3) @(negedge hash_clk);
        vec_cnt++; if (running !== 1'b0 || nonce_out[31:0] !== 32'hF8000000) begin err_cnt++; $display("FAIL hrst_halted got run=%b nonce=%h want 0/f8000000", running, nonce_out[31:0]); end
    endtask

    task automatic test_wrap;
        @(negedge hash_clk);
        vec_cnt++; if (w_nonce !== {32'hFFFFFFFD, 32'hFFFFFFFC} || w_exhausted !== 1'b0) begin err_cnt++; $display("FAIL wrap_rst got nonce=%h exh=%b want fffffffdfffffffc/0", w_nonce, w_exhausted); end
        w_reset = 1'b0;
        repeat (3) @(negedge hash_clk);
        vec_cnt++; if (w_nonce !== {32'hFFFFFFFF, 32'hFFFFFFFE} || w_exhausted !== 1'b0) begin err_cnt++; $display("FAIL wrap_issue got nonce=%h exh=%b want fffffffffffffffe/0", w_nonce, w_exhausted); end
        repeat (2) @(negedge hash_clk);
        vec_cnt++; if (w_exhausted !== 1'b1 || w_running !== 1'b0) begin err_cnt++; $display("FAIL wrap_exh got exh=%b run=%b want 1/0", w_exhausted, w_running); end
        repeat (6) @(negedge hash_clk);
        vec_cnt++; if (w_nonce[31:0] !== 32'hFFFFFFFE || w_leds !== 8'hFF || w_exhausted !== 1'b1) begin err_cnt++; $display("FAIL wrap_frozen got nonce=%h leds=%h exh=%b want fffffffe/ff/1", w_nonce[31:0], w_leds, w_exhausted); end
        w_midstate = {8{32'hDEADBEEF}};
        w_data     = {3{32'h0BADF00D}};
        w_new_work = 1'b1;
        @(negedge hash_clk);
        w_new_work = 1'b0;
        vec_cnt++; if (w_nonce !== {32'hFFFFFFFD, 32'hFFFFFFFC} || w_exhausted !== 1'b0 || w_running !== 1'b1) begin err_cnt++; $display("FAIL newwork_ctl got nonce=%h exh=%b run=%b want fffffffdfffffffc/0/1", w_nonce, w_exhausted, w_running); end
        vec_cnt++; if (w_state_out !== {8{32'hDEADBEEF}} || w_data_out !== {3{32'h0BADF00D}}) begin err_cnt++; $display("FAIL newwork_latch got state=%h data=%h want deadbeef x8 / 0badf00d x3", w_state_out[31:0], w_data_out[31:0]); end
    endtask

    initial begin
        reset = 1'b1; halt_in = 1'b1; new_work = 1'b0; gn_rd = 1'b0;
        midstate_in = '0; data_in = '0; hash_top_in = '0;
        w_reset = 1'b1; w_halt = 1'b1; w_new_work = 1'b0; w_gn_rd = 1'b0;
        w_midstate = '0; w_data = '0; w_hash = '0;
        test_reset();
        test_single_golden();
        test_both_cores();
        test_overflow();
        test_halt();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
